// File: rtl/phy_ft_n.sv
// rtl/phy_ft_n.sv - N-port PHY fault-tolerance selector with debounce, revert and force override
module phy_ft_n #(
    parameter int PORT_NUM        = 4,
    parameter int PRIMARY         = 0,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REVERT          = 1,
    parameter int REVERT_CYCLES   = 1024,
    parameter int PW              = (PORT_NUM > 2) ? $clog2(PORT_NUM) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [PORT_NUM-1:0]   phy_up,
    input  logic [2*PORT_NUM-1:0] phy_speed,
    input  logic [PORT_NUM-1:0]   phy_duplex,
    input  logic                  force_en,
    input  logic [PW-1:0]         force_port,
    output logic [PW-1:0]         active_port,
    output logic                  link_up,
    output logic [1:0]            speed,
    output logic                  full_duplex,
    output logic                  link_change,
    output logic [15:0]           switch_count
);

    // Power-of-two padded port count so any PW-bit index stays in range
    localparam int NP2 = 2 ** PW;

    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam int RW = (REVERT_CYCLES > 1) ? $clog2(REVERT_CYCLES + 1) : 1;

    // Counters saturate one below the target: the sample that reaches the
    // target is the one where the filtered condition becomes true.
    localparam logic [DW-1:0] DEB_MAX = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] REV_MAX = RW'(REVERT_CYCLES - 1);
    localparam logic [PW-1:0] PRI     = PW'(PRIMARY);

    localparam logic [0:0] NO_LINK = 1'b0;
    localparam logic [0:0] ACTIVE  = 1'b1;

    logic [DW-1:0]       deb_cnt [PORT_NUM];
    logic [PORT_NUM-1:0] up_f;
    logic [NP2-1:0]      up_pad;
    logic [2*NP2-1:0]    spd_pad;
    logic [NP2-1:0]      dup_pad;

    logic [RW-1:0]       rev_cnt;
    logic                revert_ok;

    logic [0:0]          state;
    logic [0:0]          n_state;
    logic [PW-1:0]       n_port;
    logic                n_link;
    logic [1:0]          n_speed;
    logic                n_dup;
    logic                n_change;
    logic                sw_inc;

    logic                found;
    logic [PW-1:0]       winner;
    logic                force_ok;

    // Per-port debounce counters: count consecutive high samples, restart on any low
    always_ff @(posedge clk) begin
        for (int i = 0; i < PORT_NUM; i++) begin
            if (!rst_n) begin
                deb_cnt[i] <= '0;
            end else if (!phy_up[i]) begin
                deb_cnt[i] <= '0;
            end else if (deb_cnt[i] != DEB_MAX) begin
                deb_cnt[i] <= deb_cnt[i] + 1'b1;
            end
        end
    end

    // Filtered link: rises on the final debounce sample, falls on the first low sample
    always_comb begin
        for (int i = 0; i < PORT_NUM; i++) begin
            up_f[i] = phy_up[i] && (deb_cnt[i] == DEB_MAX);
        end
    end

    // Zero-extended copies so a PW-bit index never selects past the real ports
    always_comb begin
        up_pad  = NP2'(up_f);
        spd_pad = (2 * NP2)'(phy_speed);
        dup_pad = NP2'(phy_duplex);
    end

    // Priority search: PRIMARY first, then upward wrapping modulo PORT_NUM
    always_comb begin
        found  = 1'b0;
        winner = PRI;
        for (int k = 0; k < PORT_NUM; k++) begin
            if (!found && up_f[(PRIMARY + k) % PORT_NUM]) begin
                found  = 1'b1;
                winner = PW'((PRIMARY + k) % PORT_NUM);
            end
        end
    end

    // Force is honoured only for an index that names a real port
    always_comb begin
        force_ok = force_en && (32'(force_port) < PORT_NUM);
    end

    // Revert timer: consecutive filtered-up cycles of PRIMARY while another port carries traffic
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rev_cnt <= '0;
        end else if (force_ok || (state != ACTIVE) || (active_port == PRI) || !up_f[PRIMARY]) begin
            rev_cnt <= '0;
        end else if (rev_cnt != REV_MAX) begin
            rev_cnt <= rev_cnt + 1'b1;
        end
    end

    // Revert fires on the sample where PRIMARY completes its stability window
    always_comb begin
        revert_ok = (REVERT != 0) && (state == ACTIVE) && (active_port != PRI) &&
                    up_f[PRIMARY] && (rev_cnt == REV_MAX);
    end

    // Next-state selection; a drop of the active port is handled before any revert
    always_comb begin
        n_state = state;
        n_port  = active_port;
        n_link  = link_up;
        sw_inc  = 1'b0;
        if (force_ok) begin
            n_port  = force_port;
            n_link  = up_pad[force_port];
            n_state = up_pad[force_port] ? ACTIVE : NO_LINK;
        end else begin
            case (state)
                NO_LINK: begin
                    n_link = 1'b0;
                    if (found) begin
                        n_port  = winner;
                        n_link  = 1'b1;
                        n_state = ACTIVE;
                    end
                end
                default: begin
                    n_link = 1'b1;
                    if (!up_pad[active_port]) begin
                        if (found) begin
                            n_port = winner;
                            sw_inc = 1'b1;
                        end else begin
                            n_link  = 1'b0;
                            n_state = NO_LINK;
                        end
                    end else if (revert_ok) begin
                        n_port = PRI;
                        sw_inc = 1'b1;
                    end
                end
            endcase
        end
    end

    // Visible speed/duplex of the port about to be presented; masked while the link is down
    always_comb begin
        n_speed  = n_link ? spd_pad[{n_port, 1'b0} +: 2] : 2'b00;
        n_dup    = n_link ? dup_pad[n_port] : 1'b0;
        n_change = (n_port != active_port) || (n_link != link_up) ||
                   (n_speed != speed) || (n_dup != full_duplex);
    end

    // Registered outputs, state and saturating failover counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= NO_LINK;
            active_port  <= PRI;
            link_up      <= 1'b0;
            speed        <= 2'b00;
            full_duplex  <= 1'b0;
            link_change  <= 1'b0;
            switch_count <= 16'h0000;
        end else begin
            state       <= n_state;
            active_port <= n_port;
            link_up     <= n_link;
            speed       <= n_speed;
            full_duplex <= n_dup;
            link_change <= n_change;
            if (sw_inc && (switch_count != 16'hFFFF)) begin
                switch_count <= switch_count + 16'h0001;
            end
        end
    end

endmodule

// File: tb/tb_phy_ft_n.sv
// tb/tb_phy_ft_n.sv - directed self-checking bench for phy_ft_n
module tb_phy_ft_n;

    logic clk = 1'b0;
    logic rst_n;

    // Instance A: default parameters
    logic [3:0] a_up;
    logic [7:0] a_speed;
    logic [3:0] a_dup;
    logic       a_fen;
    logic [1:0] a_fp;
    logic [1:0] a_port;
    logic       a_link;
    logic [1:0] a_spd_o;
    logic       a_dup_o;
    logic       a_lc;
    logic [15:0] a_sc;

    // Instance B: 5 ports, no debounce, non-revertive
    logic [4:0] b_up;
    logic [9:0] b_speed;
    logic [4:0] b_dup;
    logic       b_fen;
    logic [2:0] b_fp;
    logic [2:0] b_port;
    logic       b_link;
    logic [1:0] b_spd_o;
    logic       b_dup_o;
    logic       b_lc;
    logic [15:0] b_sc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    phy_ft_n u_a (
        .clk(clk), .rst_n(rst_n),
        .phy_up(a_up), .phy_speed(a_speed), .phy_duplex(a_dup),
        .force_en(a_fen), .force_port(a_fp),
        .active_port(a_port), .link_up(a_link), .speed(a_spd_o),
        .full_duplex(a_dup_o), .link_change(a_lc), .switch_count(a_sc)
    );

    phy_ft_n #(
        .PORT_NUM(5), .PRIMARY(0), .DEBOUNCE_CYCLES(1), .REVERT(0), .REVERT_CYCLES(8)
    ) u_b (
        .clk(clk), .rst_n(rst_n),
        .phy_up(b_up), .phy_speed(b_speed), .phy_duplex(b_dup),
        .force_en(b_fen), .force_port(b_fp),
        .active_port(b_port), .link_up(b_link), .speed(b_spd_o),
        .full_duplex(b_dup_o), .link_change(b_lc), .switch_count(b_sc)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_n   = 1'b0;
        a_up    = 4'b0000;
        a_speed = 8'b00_01_10_10;
        a_dup   = 4'b0010;
        a_fen   = 1'b0;
        a_fp    = 2'd0;
        b_up    = 5'b00000;
        b_speed = 10'b00_00_10_00_01;
        b_dup   = 5'b00100;
        b_fen   = 1'b0;
        b_fp    = 3'd0;
        step(2);

        check("rst_port", 32'(a_port), 32'd0);
        check("rst_link", 32'(a_link), 32'd0);
        check("rst_speed", 32'(a_spd_o), 32'd0);
        check("rst_dup", 32'(a_dup_o), 32'd0);
        check("rst_lc", 32'(a_lc), 32'd0);
        check("rst_sc", 32'(a_sc), 32'd0);

        // Port 1 comes up: selected on its 16th high sample
        rst_n = 1'b1;
        a_up  = 4'b0010;
        step(15);
        check("deb_not_yet", 32'(a_link), 32'd0);
        check("deb_no_lc", 32'(a_lc), 32'd0);
        step(1);
        check("up_port", 32'(a_port), 32'd1);
        check("up_link", 32'(a_link), 32'd1);
        check("up_speed", 32'(a_spd_o), 32'd2);
        check("up_dup", 32'(a_dup_o), 32'd1);
        check("up_lc", 32'(a_lc), 32'd1);
        check("up_sc", 32'(a_sc), 32'd0);
        step(1);
        check("up_lc_end", 32'(a_lc), 32'd0);

        // Port 0 bounces: 15 high, 1 low, never qualifies
        for (int r = 0; r < 3; r++) begin
            a_up = 4'b0011;
            step(15);
            a_up = 4'b0010;
            step(1);
            check("bounce_port", 32'(a_port), 32'd1);
        end

        // Port 0 held: up at sample 16, revert after 1024 filtered samples
        a_up = 4'b0011;
        step(1038);
        check("rev_before", 32'(a_port), 32'd1);
        check("rev_before_lc", 32'(a_lc), 32'd0);
        step(1);
        check("rev_port", 32'(a_port), 32'd0);
        check("rev_sc", 32'(a_sc), 32'd1);
        check("rev_lc", 32'(a_lc), 32'd1);

        // Failover from port 0 to port 2 with ports 2,3 up
        a_up = 4'b1101;
        step(20);
        check("fo_pre_port", 32'(a_port), 32'd0);
        check("fo_pre_lc", 32'(a_lc), 32'd0);
        a_up = 4'b1100;
        step(1);
        check("fo_port", 32'(a_port), 32'd2);
        check("fo_lc", 32'(a_lc), 32'd1);
        check("fo_sc", 32'(a_sc), 32'd2);
        check("fo_speed", 32'(a_spd_o), 32'd1);

        // Speed change on the active port: pulse only
        a_speed = 8'b00_10_10_10;
        step(1);
        check("spd_chg_speed", 32'(a_spd_o), 32'd2);
        check("spd_chg_lc", 32'(a_lc), 32'd1);
        check("spd_chg_port", 32'(a_port), 32'd2);
        step(1);
        check("spd_chg_lc_end", 32'(a_lc), 32'd0);

        // All ports down
        a_up = 4'b0000;
        step(1);
        check("down_link", 32'(a_link), 32'd0);
        check("down_port", 32'(a_port), 32'd2);
        check("down_lc", 32'(a_lc), 32'd1);
        check("down_sc", 32'(a_sc), 32'd2);

        // Force onto a down port
        a_fen = 1'b1;
        a_fp  = 2'd3;
        step(1);
        check("frc_port", 32'(a_port), 32'd3);
        check("frc_link", 32'(a_link), 32'd0);
        check("frc_lc", 32'(a_lc), 32'd1);
        a_up = 4'b0001;
        step(16);
        check("frc_hold_port", 32'(a_port), 32'd3);
        check("frc_hold_lc", 32'(a_lc), 32'd0);
        a_fen = 1'b0;
        step(1);
        check("rel_port", 32'(a_port), 32'd0);
        check("rel_link", 32'(a_link), 32'd1);
        check("rel_lc", 32'(a_lc), 32'd1);
        check("rel_sc", 32'(a_sc), 32'd2);

        // Failover to port 1, then reset mid revert count
        a_up = 4'b0011;
        step(20);
        a_up = 4'b0010;
        step(1);
        check("fo2_port", 32'(a_port), 32'd1);
        check("fo2_sc", 32'(a_sc), 32'd3);
        a_up = 4'b0011;
        step(500);
        check("mid_port", 32'(a_port), 32'd1);
        rst_n = 1'b0;
        step(1);
        check("mrst_port", 32'(a_port), 32'd0);
        check("mrst_link", 32'(a_link), 32'd0);
        check("mrst_sc", 32'(a_sc), 32'd0);
        check("mrst_lc", 32'(a_lc), 32'd0);
        rst_n = 1'b1;
        step(15);
        check("mrst_deb", 32'(a_link), 32'd0);
        step(1);
        check("mrst_up_port", 32'(a_port), 32'd0);
        check("mrst_up_link", 32'(a_link), 32'd1);
        check("mrst_up_sc", 32'(a_sc), 32'd0);

        // Instance B: non-revertive failover
        b_up = 5'b00101;
        step(1);
        check("b_up_port", 32'(b_port), 32'd0);
        check("b_up_lc", 32'(b_lc), 32'd1);
        check("b_up_speed", 32'(b_spd_o), 32'd1);
        b_up = 5'b00100;
        step(1);
        check("b_fo_port", 32'(b_port), 32'd2);
        check("b_fo_sc", 32'(b_sc), 32'd1);
        check("b_fo_speed", 32'(b_spd_o), 32'd2);
        check("b_fo_dup", 32'(b_dup_o), 32'd1);
        b_up = 5'b00101;
        step(1);
        check("b_norev_lc", 32'(b_lc), 32'd0);
        step(20);
        check("b_norev_port", 32'(b_port), 32'd2);
        check("b_norev_sc", 32'(b_sc), 32'd1);

        // Out-of-range force ignored, then in-range force on a down port, then release
        b_fen = 1'b1;
        b_fp  = 3'd5;
        step(1);
        check("b_frc5_port", 32'(b_port), 32'd2);
        check("b_frc5_lc", 32'(b_lc), 32'd0);
        b_fp = 3'd4;
        step(1);
        check("b_frc4_port", 32'(b_port), 32'd4);
        check("b_frc4_link", 32'(b_link), 32'd0);
        check("b_frc4_lc", 32'(b_lc), 32'd1);
        b_fen = 1'b0;
        step(1);
        check("b_rel_port", 32'(b_port), 32'd0);
        check("b_rel_link", 32'(b_link), 32'd1);
        check("b_rel_sc", 32'(b_sc), 32'd1);

        // Alternate ports 0/1 every cycle: one failover per cycle up to saturation
        for (int i = 0; i < 65533; i++) begin
            b_up = (i % 2 == 0) ? 5'b00010 : 5'b00001;
            step(1);
        end
        check("b_sat_pre", 32'(b_sc), 32'hFFFE);
        for (int i = 65533; i < 65540; i++) begin
            b_up = (i % 2 == 0) ? 5'b00010 : 5'b00001;
            step(1);
        end
        check("b_sat", 32'(b_sc), 32'hFFFF);
        check("b_sat_lc", 32'(b_lc), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/phy_ft_n.md
Name: phy_ft_n

Overview:
- N-port generalisation of the dual-redundancy PHY fault-tolerance selector.
- Monitors link status, speed and duplex of PORT_NUM PHYs and picks one active port.
- Presents the active port's link state to the NIC MAC/status logic and pulses link_change for the LSC interrupt.
- Adds link-up debounce, configurable primary port, optional revertive failover, software force override and a saturating failover counter.

Parameters:
- PORT_NUM, 4, number of PHY ports (2..8)
- PRIMARY, 0, preferred port index (0..PORT_NUM-1)
- DEBOUNCE_CYCLES, 16, consecutive cycles phy_up must stay high before the port counts as up
- REVERT, 1, 1 = return to PRIMARY once it is stable; 0 = non-revertive
- REVERT_CYCLES, 1024, consecutive cycles PRIMARY must be filtered-up before reverting
- PW, $clog2(PORT_NUM) (minimum 1), port index width

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous reset, active low
- phy_up  in  PORT_NUM  raw per-port link-up
- phy_speed  in  2*PORT_NUM  per-port speed, 2 bits each (00=10M, 01=100M, 10=1000M)
- phy_duplex  in  PORT_NUM  per-port full duplex
- force_en  in  1  software override enable
- force_port  in  PW  override port index
- active_port  out  PW  selected port
- link_up  out  1  selected port filtered-up
- speed  out  2  selected port speed
- full_duplex  out  1  selected port duplex
- link_change  out  1  single-cycle pulse on any visible link state change
- switch_count  out  16  failover/revert count, saturates at 16'hFFFF

Behaviour:
- Reset (rst_n=0 sampled at clk edge):
  - active_port=PRIMARY, link_up=0, speed=2'b00, full_duplex=0, link_change=0, switch_count=0.
  - All debounce and revert counters cleared; state=NO_LINK.
  - Reset asserted mid-operation aborts immediately; the next cycle after release behaves as from power-up.
- Per-port filter:
  - up_f[i] rises after phy_up[i] has been 1 for DEBOUNCE_CYCLES consecutive cycles.
  - up_f[i] falls in the same cycle phy_up[i] is sampled 0 (fault detection is immediate).
  - The counter restarts on any 0.
- Priority search order: PRIMARY, PRIMARY+1, … wrapping modulo PORT_NUM. The first port with up_f=1 wins.
- State machine (normal mode, force_en=0):
  - NO_LINK:
    - link_up=0.
    - If any up_f=1, select the winner, go to ACTIVE and pulse link_change.
    - switch_count is not incremented.
  - ACTIVE, active port drops (up_f[active]=0):
    - If another port is up, switch to the winner, increment switch_count and pulse link_change.
    - Otherwise go to NO_LINK, keep active_port and pulse link_change.
  - ACTIVE, revert condition:
    - Applies when REVERT=1, active≠PRIMARY and up_f[PRIMARY] has been 1 for REVERT_CYCLES consecutive cycles.
    - Switch to PRIMARY, increment switch_count, pulse link_change.
    - The revert counter clears on any up_f[PRIMARY]=0 and whenever active==PRIMARY.
  - ACTIVE, speed or duplex change on the active port: pulse link_change, no switch.
- Simultaneous events:
  - Active-port drop takes precedence over revert; the priority search handles it and may select PRIMARY.
  - Multiple ports rising in the same cycle: the priority order decides.
- Force mode:
  - Applies when force_en=1 and force_port<PORT_NUM.
  - active_port=force_port next cycle; link_up=up_f[force_port]; failover and revert are suppressed.
  - Entering or leaving force pulses link_change if active_port or link_up changes; switch_count is unchanged.
  - Out-of-range force_port is ignored and normal mode continues.
  - On leaving force, in the next cycle: if the forced port is up, stay in ACTIVE on it; else re-run the priority search.
- Timing:
  - All outputs are registered.
  - speed and full_duplex follow the active port with 1-cycle latency after any input change or selection change.
  - link_change is asserted in the same cycle the new active_port and link_up become visible.
- link_change never stays high for 2 consecutive cycles unless two distinct changes occur on consecutive cycles.
- switch_count holds at 16'hFFFF once reached.

Test Plan:
- Defaults. Reset, then phy_up=4'b0010 with speed 10 on port 1 → after 16 cycles: active_port=1, link_up=1, speed=2'b10, one link_change pulse, switch_count=0.
- Debounce. phy_up[0] high for 15 cycles then low for 1 cycle, repeated → port 0 is never selected. Once held for 16 cycles → revert timer starts; after a further 1024 cycles active_port=0 and switch_count=1.
- Failover. Active port 0, ports 2 and 3 up; drop phy_up[0] → the next cycle has active_port=2, a link_change pulse and switch_count incremented. Then drop all ports → link_up=0, active_port stays 2.
- REVERT=0. Repeat the previous scenario and restore port 0 → active_port stays 2 indefinitely; no link_change pulse.
- Force. force_en=1, force_port=3 with port 3 down → active_port=3, link_up=0. With force_port=5 → ignored. Release force → priority search selects PRIMARY if it is up.
- Mid-operation and saturation. Assert rst_n=0 during the revert count → all outputs return to reset values. Preload 65535 failovers via toggling → switch_count stays at 16'hFFFF.
